demux14_rr_4b: RTL and testbench



---
 rtl/demux14_rr_4b_pkg.sv | 28 ++
 rtl/demux_lane_4b.sv | 29 ++
 rtl/demux14_rr_4b.sv | 94 +++++++++
 tb/tb_demux14_rr_4b.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/demux14_rr_4b_pkg.sv
// Shared types and constants for the round-robin 1:4 valid demultiplexer.
// Lane indexing, pointer width and the per-cycle steering decision live here.
package demux14_rr_4b_pkg;

    localparam int BW_DEFAULT     = 4;
    localparam int DROP_W_DEFAULT = 8;
    localparam int LANES          = 4;
    localparam int PTR_W          = 2;

    typedef logic [PTR_W-1:0] lane_idx_t;

    localparam lane_idx_t LANE0 = 2'd0;
    localparam lane_idx_t LANE1 = 2'd1;
    localparam lane_idx_t LANE2 = 2'd2;
    localparam lane_idx_t LANE3 = 2'd3;

    typedef enum logic [1:0] {
        ACT_IDLE   = 2'd0,
        ACT_ACCEPT = 2'd1,
        ACT_DROP   = 2'd2
    } act_e;

    // Pointer width equals log2(LANES), so plain increment wraps 3 -> 0.
    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return idx + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/demux_lane_4b.sv
// One output lane holding register with valid flag.
// A write in the same cycle as a pop wins; a pop alone clears valid but keeps the data.
module demux_lane_4b
    import demux14_rr_4b_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          pop,
    input  logic [BW-1:0] data_in,
    output logic [BW-1:0] data_out,
    output logic          valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (wr_en) begin
            data_out <= data_in;
            valid    <= 1'b1;
        end else if (pop) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/demux14_rr_4b.sv
// Round-robin 1:4 demultiplexer: steers each valid word to the next lane in rotation,
// holds it until popped, and counts (saturating) words dropped because the target lane was full.
module demux14_rr_4b
    import demux14_rr_4b_pkg::*;
#(
    parameter int BW     = BW_DEFAULT,
    parameter int DROP_W = DROP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BW-1:0]     data_in,
    input  logic              valid_in,
    input  logic              pop0,
    input  logic              pop1,
    input  logic              pop2,
    input  logic              pop3,
    output logic [BW-1:0]     out0,
    output logic [BW-1:0]     out1,
    output logic [BW-1:0]     out2,
    output logic [BW-1:0]     out3,
    output logic              out0_valid,
    output logic              out1_valid,
    output logic              out2_valid,
    output logic              out3_valid,
    output logic [PTR_W-1:0]  dest,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    lane_idx_t        ptr;
    act_e             act;
    logic [LANES-1:0] pop_vec;
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] wr_en;
    logic [BW-1:0]    lane_data [LANES];

    assign pop_vec = {pop3, pop2, pop1, pop0};

    // A full target lane still accepts if its consumer drains it this same cycle.
    always_comb begin
        act = ACT_IDLE;
        if (valid_in) begin
            if (!lane_valid[ptr] || pop_vec[ptr]) begin
                act = ACT_ACCEPT;
            end else begin
                act = ACT_DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= LANE0;
        end else if (act == ACT_ACCEPT) begin
            ptr <= next_lane(ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (act == ACT_DROP && drop_count != DROP_MAX) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign wr_en[i] = (act == ACT_ACCEPT) && (ptr == lane_idx_t'(i));

        demux_lane_4b #(
            .BW (BW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en[i]),
            .pop      (pop_vec[i]),
            .data_in  (data_in),
            .data_out (lane_data[i]),
            .valid    (lane_valid[i])
        );
    end

    assign out0       = lane_data[LANE0];
    assign out1       = lane_data[LANE1];
    assign out2       = lane_data[LANE2];
    assign out3       = lane_data[LANE3];
    assign out0_valid = lane_valid[LANE0];
    assign out1_valid = lane_valid[LANE1];
    assign out2_valid = lane_valid[LANE2];
    assign out3_valid = lane_valid[LANE3];
    assign dest       = ptr;

endmodule

// File: tb/tb_demux14_rr_4b.sv
// Directed self-checking bench for demux14_rr_4b with hand-computed expectations.
module tb_demux14_rr_4b;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       valid_in;
    logic       pop0, pop1, pop2, pop3;
    logic [3:0] out0, out1, out2, out3;
    logic       out0_valid, out1_valid, out2_valid, out3_valid;
    logic [1:0] dest;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    demux14_rr_4b #(.BW(4), .DROP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .pop0       (pop0),
        .pop1       (pop1),
        .pop2       (pop2),
        .pop3       (pop3),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .dest       (dest),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] valids();
        return {out3_valid, out2_valid, out1_valid, out0_valid};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic [3:0] p);
        valid_in = v;
        data_in  = d;
        {pop3, pop2, pop1, pop0} = p;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = 4'h0;
        {pop3, pop2, pop1, pop0} = 4'b0000;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b1, 4'hF, 4'b1111);
        reset = 1'b0;
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_valids"}, 32'(valids()), 32'h0);
        checkOutput({tag, "_data"}, 32'({out3, out2, out1, out0}), 32'h0);
        checkOutput({tag, "_dest"}, 32'(dest), 32'd0);
        checkOutput({tag, "_drop"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 4'h0;
        {pop3, pop2, pop1, pop0} = 4'b0000;

        // Reset with valid_in and pops active must leave everything cleared.
        doReset();
        doReset();
        checkAllClear("reset");

        // Fill all four lanes in rotation.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 4'b0000);
        checkOutput("fill_data", 32'({out3, out2, out1, out0}), 32'h4321);
        checkOutput("fill_valids", 32'(valids()), 32'hF);
        checkOutput("fill_dest", 32'(dest), 32'd0);
        checkOutput("fill_drop", 32'(drop_count), 32'd0);

        // Fifth word hits a full lane and is dropped.
        applyStimulus(1'b1, 4'h5, 4'b0000);
        checkOutput("drop_out0", 32'(out0), 32'h1);
        checkOutput("drop_dest", 32'(dest), 32'd0);
        checkOutput("drop_count1", 32'(drop_count), 32'd1);

        // Pop alone clears valid but retains data; next word refills lane 0.
        applyStimulus(1'b0, 4'hA, 4'b0001);
        checkOutput("pop0_valids", 32'(valids()), 32'hE);
        checkOutput("pop0_retain", 32'(out0), 32'h1);
        checkOutput("pop0_dest", 32'(dest), 32'd0);
        applyStimulus(1'b1, 4'h6, 4'b0000);
        checkOutput("refill_out0", 32'(out0), 32'h6);
        checkOutput("refill_dest", 32'(dest), 32'd1);
        checkOutput("refill_valids", 32'(valids()), 32'hF);

        // Write and pop on the same lane: write wins; pop1 proceeds in parallel.
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 4'b0000);
        applyStimulus(1'b1, 4'h9, 4'b0011);
        checkOutput("ww_out0", 32'(out0), 32'h9);
        checkOutput("ww_valids", 32'(valids()), 32'hD);
        checkOutput("ww_out1_retain", 32'(out1), 32'h2);
        checkOutput("ww_dest", 32'(dest), 32'd1);
        checkOutput("ww_drop", 32'(drop_count), 32'd0);

        // Pop on an empty lane is ignored; pop on a valid lane with no write clears it.
        doReset();
        applyStimulus(1'b0, 4'h0, 4'b0100);
        checkAllClear("emptypop");
        applyStimulus(1'b1, 4'hA, 4'b0000);
        applyStimulus(1'b1, 4'hB, 4'b0000);
        applyStimulus(1'b0, 4'h0, 4'b0010);
        checkOutput("pop1_valids", 32'(valids()), 32'h1);
        checkOutput("pop1_data", 32'(out1), 32'hB);
        checkOutput("pop1_dest", 32'(dest), 32'd2);

        // Sustained throughput: every lane drained each cycle, no drops.
        doReset();
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 4'(i), 4'b1111);
        checkOutput("tput_dest", 32'(dest), 32'd0);
        checkOutput("tput_drop", 32'(drop_count), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'b0000);
        checkOutput("tput_data", 32'({out3, out2, out1, out0}), 32'h8765);

        // Saturating drop counter.
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 4'b0000);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'hC, 4'b0000);
        checkOutput("sat_mid", 32'(drop_count), 32'd10);
        for (int i = 10; i < 300; i++) applyStimulus(1'b1, 4'hC, 4'b0000);
        checkOutput("sat_max", 32'(drop_count), 32'd255);
        checkOutput("sat_dest", 32'(dest), 32'd0);
        checkOutput("sat_out0", 32'(out0), 32'h1);

        // Mid-operation reset discards held words without counting drops.
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 4'b0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hE, 4'b0000);
        applyStimulus(1'b0, 4'h0, 4'b0011);
        applyStimulus(1'b1, 4'h5, 4'b0000);
        applyStimulus(1'b1, 4'h6, 4'b0000);
        checkOutput("pre_rst_dest", 32'(dest), 32'd2);
        checkOutput("pre_rst_drop", 32'(drop_count), 32'd3);
        reset = 1'b1;
        applyStimulus(1'b1, 4'h7, 4'b0000);
        reset = 1'b0;
        checkAllClear("midreset");
        applyStimulus(1'b1, 4'h8, 4'b0000);
        checkOutput("post_rst_out0", 32'(out0), 32'h8);
        checkOutput("post_rst_valids", 32'(valids()), 32'h1);
        checkOutput("post_rst_dest", 32'(dest), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
